usb_pc_pulse_out: RTL and testbench

Avalon-MM slave output port that drives the single-bit strobe line toward the USB bridge/PC side. It is the output counterpart of the USB PC input capture port. Software sets a static line level or launches a timed pulse of programmable width. Completion is flagged in a sticky status bit and, optionally, on an interrupt.

---
 rtl/usb_pc_pkg.sv | 21 ++
 rtl/usb_pc_pulse_out_if.sv | 18 +
 rtl/usb_pc_pulse_timer.sv | 34 +++
 rtl/usb_pc_pulse_out.sv | 141 ++++++++++++++
 tb/tb_usb_pc_pulse_out.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pc_pkg.sv
// Shared definitions for the USB PC strobe ports: register addresses,
// pulse FSM states and register bit positions.
package usb_pc_pkg;

  localparam logic [1:0] ADDR_LEVEL  = 2'd0;
  localparam logic [1:0] ADDR_LENGTH = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_state_e;

  localparam int LEVEL_BIT       = 0;
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_BUSY_BIT   = 0;
  localparam int CTRL_MASK_BIT   = 1;
  localparam int STATUS_DONE_BIT = 0;

endpackage

// File: rtl/usb_pc_pulse_out_if.sv
// Avalon-MM slave bus bundle for the USB PC pulse output port.
interface usb_pc_pulse_out_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/usb_pc_pulse_timer.sv
// Loadable pulse-width down-counter. A load value of 0 is treated as 1.
// tc_o flags the last cycle of a pulse (count == 1); the counter rests at 0.
module usb_pc_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload wins over decrement; hold at zero when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (len_i == '0) ? CNT_W'(1) : len_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/usb_pc_pulse_out.sv
// USB PC pulse output port: Avalon-MM register file, pulse FSM, registered
// strobe line. Optional completion interrupt under USB_PC_PULSE_OUT_IRQ_EN.
module usb_pc_pulse_out
  import usb_pc_pkg::*;
#(
  parameter int   CNT_W     = 16,
  parameter logic RST_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  usb_pc_pulse_out_if.slave   bus,
  output logic                out_port
`ifdef USB_PC_PULSE_OUT_IRQ_EN
  ,
  output logic                irq
`endif
);

  pulse_state_e     state_q;
  logic             busy_q;
  logic             done_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] len_q;
  logic             mask_q;
  logic             out_q;
  logic [31:0]      rd_q;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             start_req;
  logic             load;
  logic             pulse_d;
  logic             tc;
  logic             unused_wd;

  assign unused_wd = ^bus.writedata;

  // Decode writes and work out the pulse state that follows this edge, so
  // out_port can be registered with no extra cycle of latency.
  always_comb begin
    wr_en     = bus.chipselect & ~bus.write_n;
    start_req = wr_en && (bus.address == ADDR_CTRL) && bus.writedata[CTRL_START_BIT];
    level_d   = level_q;
    if (wr_en && (bus.address == ADDR_LEVEL)) level_d = bus.writedata[LEVEL_BIT];
    // A start on the terminal cycle re-arms immediately (zero idle gap).
    load    = start_req && ((state_q == ST_IDLE) || tc);
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE:  pulse_d = start_req;
      ST_PULSE: pulse_d = !tc || start_req;
      default:  pulse_d = 1'b0;
    endcase
  end

  usb_pc_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .len_i  (len_q),
    .tc_o   (tc)
  );

  // Software-visible storage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= RST_LEVEL;
      len_q   <= CNT_W'(1);
      mask_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      if (wr_en && (bus.address == ADDR_LENGTH)) len_q  <= bus.writedata[CNT_W-1:0];
      if (wr_en && (bus.address == ADDR_CTRL))   mask_q <= bus.writedata[CTRL_MASK_BIT];
    end
  end

  // Pulse FSM with registered busy/done; completion beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (wr_en && (bus.address == ADDR_STATUS)) done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            state_q <= ST_PULSE;
            busy_q  <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (tc) begin
            done_q <= 1'b1;
            if (!start_req) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read mux from current register contents.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_LEVEL:  rd_mux[LEVEL_BIT] = level_q;
      ADDR_LENGTH: rd_mux[CNT_W-1:0] = len_q;
      ADDR_CTRL: begin
        rd_mux[CTRL_BUSY_BIT] = busy_q;
        rd_mux[CTRL_MASK_BIT] = mask_q;
      end
      ADDR_STATUS: rd_mux[STATUS_DONE_BIT] = done_q;
      default:     rd_mux = '0;
    endcase
  end

  // Registered read data and output line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      out_q <= RST_LEVEL;
    end else begin
      rd_q  <= rd_mux;
      out_q <= level_d ^ pulse_d;
    end
  end

  assign bus.readdata = rd_q;
  assign out_port     = out_q;

`ifdef USB_PC_PULSE_OUT_IRQ_EN
  assign irq = done_q & mask_q;
`endif

endmodule

// File: tb/tb_usb_pc_pulse_out.sv
// Self-checking bench for usb_pc_pulse_out. Pulses are modelled as an
// absolute start edge plus a width; expected outputs follow from that.
module tb_usb_pc_pulse_out;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic out_port;
`ifdef USB_PC_PULSE_OUT_IRQ_EN
  logic irq;
`endif

  usb_pc_pulse_out_if bus();

  usb_pc_pulse_out #(.CNT_W(CNT_W), .RST_LEVEL(1'b0)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
`ifdef USB_PC_PULSE_OUT_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          edge_n = 0;
  int          p_start = 0;
  int          p_len = 0;
  bit          m_valid = 0;
  bit          m_level, m_mask, m_done, m_out;
  int          m_len;
  logic [31:0] m_rd;

  always @(posedge clk) begin
    bit active_before, ends_now, active_after, wr;
    edge_n++;
    if (reset) begin
      m_valid = 1; m_level = 0; m_len = 1; m_mask = 0; m_done = 0;
      m_rd = 0; m_out = 0; p_len = 0; p_start = 0;
    end else begin
      active_before = (p_len > 0) && (edge_n - 1 >= p_start) && (edge_n - 1 < p_start + p_len);
      ends_now      = active_before && (edge_n == p_start + p_len);
      case (bus.address)
        2'd0: m_rd = {31'b0, m_level};
        2'd1: m_rd = m_len;
        2'd2: m_rd = {30'b0, m_mask, active_before};
        default: m_rd = {31'b0, m_done};
      endcase
      wr = bus.chipselect && !bus.write_n;
      if (wr && bus.address == 2'd3) m_done = 0;
      if (ends_now) m_done = 1;
      if (wr && bus.address == 2'd0) m_level = bus.writedata[0];
      if (wr && bus.address == 2'd1) m_len = int'(bus.writedata[CNT_W-1:0]);
      if (wr && bus.address == 2'd2) begin
        m_mask = bus.writedata[1];
        if (bus.writedata[0] && (!active_before || ends_now)) begin
          p_start = edge_n;
          p_len   = (m_len == 0) ? 1 : m_len;
        end
      end
      active_after = (p_len > 0) && (edge_n >= p_start) && (edge_n < p_start + p_len);
      m_out = m_level ^ active_after;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("out_port", {31'b0, out_port}, {31'b0, m_out});
      check("readdata", bus.readdata, m_rd);
`ifdef USB_PC_PULSE_OUT_IRQ_EN
      check("irq", {31'b0, irq}, {31'b0, m_done & m_mask});
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1; bus.write_n = 0; bus.address = a; bus.writedata = d;
    tick();
    bus.chipselect = 0; bus.write_n = 1;
  endtask

  task automatic rd_check(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.address = a;
    tick();
    check(name, bus.readdata, exp);
  endtask

  // Count cycles out_port stays at lvl, starting now.
  task automatic measure(input logic lvl, input int exp, input string name);
    int cnt = 0;
    while (out_port === lvl && cnt < 100) begin
      cnt++;
      tick();
    end
    check(name, cnt, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; bus.chipselect = 0; bus.write_n = 1; bus.address = 0; bus.writedata = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;

    rd_check(2'd0, 0, "rst_level");
    rd_check(2'd1, 1, "rst_length");
    rd_check(2'd2, 0, "rst_ctrl");
    rd_check(2'd3, 0, "rst_status");
    check("rst_out", {31'b0, out_port}, 0);

    wr(2'd0, 1);
    check("level_out", {31'b0, out_port}, 1);
    rd_check(2'd0, 1, "level_rd");
    wr(2'd0, 0);

    // 5-cycle pulse, done sticky, cleared by STATUS write
    wr(2'd1, 5);
    wr(2'd2, 1);
    measure(1'b1, 5, "pulse5_width");
    rd_check(2'd3, 1, "pulse5_done");
    rd_check(2'd2, 0, "pulse5_busy_clr");
    wr(2'd3, 0);
    rd_check(2'd3, 0, "done_clear");

    // LENGTH=0 behaves as 1
    wr(2'd1, 0);
    wr(2'd2, 1);
    measure(1'b1, 1, "len0_width");

    // second start during a 10-cycle pulse is ignored
    wr(2'd1, 10);
    wr(2'd2, 1);
    rd_check(2'd2, 1, "busy_mid");
    wr(2'd2, 1);
    measure(1'b1, 8, "restart_ignored");

    // LENGTH write during pulse only affects the next one
    wr(2'd1, 4);
    wr(2'd2, 1);
    wr(2'd1, 7);
    measure(1'b1, 3, "len_during_pulse");
    wr(2'd2, 1);
    measure(1'b1, 7, "len_next_pulse");

    // LEVEL write during pulse keeps out_port inverted vs the new level
    wr(2'd1, 6);
    wr(2'd2, 1);
    wr(2'd0, 1);
    check("level_inv", {31'b0, out_port}, 0);
    measure(1'b0, 5, "level_inv_width");
    wr(2'd0, 0);

    // back-to-back: start at N+L-1 ignored, start at N+L accepted with no gap
    wr(2'd1, 3);
    wr(2'd2, 1);
    tick();
    wr(2'd2, 1);
    check("b2b_hold", {31'b0, out_port}, 1);
    wr(2'd2, 1);
    measure(1'b1, 3, "b2b_second");

    // STATUS write coincident with completion: done wins
    wr(2'd3, 0);
    wr(2'd1, 3);
    wr(2'd2, 1);
    tick();
    tick();
    wr(2'd3, 0);
    rd_check(2'd3, 1, "done_race");

    // irq mask is plain storage; irq follows done & mask when present
    wr(2'd3, 0);
    wr(2'd2, 2);
    rd_check(2'd2, 2, "mask_rd");
    wr(2'd1, 2);
    wr(2'd2, 3);
    tick();
`ifdef USB_PC_PULSE_OUT_IRQ_EN
    check("irq_low", {31'b0, irq}, 0);
`endif
    tick();
`ifdef USB_PC_PULSE_OUT_IRQ_EN
    check("irq_rise", {31'b0, irq}, 1);
`endif
    wr(2'd3, 0);
`ifdef USB_PC_PULSE_OUT_IRQ_EN
    check("irq_fall", {31'b0, irq}, 0);
`endif
    rd_check(2'd3, 0, "irq_done_clr");

    // reset asserted at pulse cycle 3 truncates the pulse
    wr(2'd1, 8);
    wr(2'd2, 1);
    tick();
    tick();
    reset = 1;
    tick();
    check("rst_mid_out", {31'b0, out_port}, 0);
    reset = 0;
    rd_check(2'd2, 0, "rst_mid_busy");
    rd_check(2'd3, 0, "rst_mid_done");
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
